// File: rtl/spi_regfile_slave.sv
// SPI register-file slave. The SPI pins are oversampled on the system clock.
// The first byte of a frame sets the register address. Each later byte writes
// a config register (writes to other addresses are dropped) and then advances
// the address by one. The read window drives a one-hot channel select and a
// register index to an external counter mux. The selected byte returns on MISO.
// A frame ends when sclk has been quiet for IDLE_RST clocks.
module spi_regfile_slave #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int NUM_CFG     = 3,
    parameter int CFG_BASE    = 1,
    parameter int RD_BASE     = 4,
    parameter int NUM_CH      = 8,
    parameter int REGS_PER_CH = 7,
    parameter int IDLE_RST    = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              sclk,
    input  logic                              serial_in,
    input  logic [DATA_W-1:0]                 rd_data,
    output logic                              serial_out,
    output logic [NUM_CFG*DATA_W-1:0]         cfg_regs,
    output logic [NUM_CH-1:0]                 load_cnt_ser,
    output logic [$clog2(REGS_PER_CH)-1:0]    select_reg,
    output logic [ADDR_W-1:0]                 addr,
    output logic                              frame_active,
    output logic                              byte_done
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IDX_W = $clog2(REGS_PER_CH);
    localparam int BC_W  = $clog2(DATA_W);
    localparam int IC_W  = $clog2(IDLE_RST + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    // Synchroniser taps: [0] and [1] are the metastability pair; [2] is the previous level.
    logic [2:0] sclk_q;
    logic [2:0] sin_q;
    logic       rise_q, fall_q;

    logic [1:0]                 state_q,   state_d;
    logic [BC_W-1:0]            bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]          rx_q,      rx_d;
    logic [IC_W-1:0]            idle_q,    idle_d;
    logic [ADDR_W-1:0]          addr_q,    addr_d;
    logic [NUM_CFG-1:0][DATA_W-1:0] cfg_q, cfg_d;
    logic [DATA_W-1:0]          tx_q,      tx_d;
    logic                       load_q,    load_d;
    logic                       done_q,    done_d;
    logic                       win_q,     win_d;
    logic [CH_W-1:0]            ch_q,      ch_d;
    logic [IDX_W-1:0]           idx_q,     idx_d;

    logic [DATA_W-1:0] byte_in;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] tx_val;
    logic              rc_win;
    logic [CH_W-1:0]   rc_ch;
    logic [IDX_W-1:0]  rc_idx;
    int                off;

    // Two-flop synchroniser plus one history flop. Edge strobes are registered, so a pin edge gives a strobe 3 clk later.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q <= '0;
            sin_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk};
            sin_q  <= {sin_q[1:0], serial_in};
            rise_q <= sclk_q[1] & ~sclk_q[2];
            fall_q <= ~sclk_q[1] & sclk_q[2];
        end
    end

    // sin_q[2] is delayed by the same amount as the rise strobe, so it holds the bit that belongs to this rise.
    assign byte_in  = {rx_q[DATA_W-2:0], sin_q[2]};
    assign addr_nxt = (state_q == S_ADDR) ? ADDR_W'(byte_in) : addr_q + ADDR_W'(1);

    // Comparator chain that finds the channel and index of a non-sequential address; a divider is not needed.
    always_comb begin
        rc_win = 1'b0;
        rc_ch  = '0;
        rc_idx = '0;
        off    = int'(addr_nxt) - RD_BASE;
        for (int c = 0; c < NUM_CH; c++) begin
            if (off >= c * REGS_PER_CH && off < (c + 1) * REGS_PER_CH) begin
                rc_win = 1'b1;
                rc_ch  = CH_W'(c);
                rc_idx = IDX_W'(off - c * REGS_PER_CH);
            end
        end
    end

    // Value presented on MISO for the current address. The cfg and mux state have already settled by the load cycle.
    always_comb begin
        tx_val = '0;
        for (int k = 0; k < NUM_CFG; k++) begin
            if (addr_q == ADDR_W'(CFG_BASE + k)) tx_val = cfg_q[k];
        end
        if (win_q) tx_val = rd_data;
    end

    // Frame FSM, idle timeout, byte commit, and tx shift/load.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        idle_d    = idle_q;
        addr_d    = addr_q;
        cfg_d     = cfg_q;
        tx_d      = tx_q;
        load_d    = 1'b0;
        done_d    = 1'b0;
        win_d     = win_q;
        ch_d      = ch_q;
        idx_d     = idx_q;

        if (state_q == S_IDLE || rise_q || fall_q)
            idle_d = '0;
        else if (idle_q != IC_W'(IDLE_RST))
            idle_d = idle_q + IC_W'(1);

        // The fall right after a byte's last rise has bit_cnt == 0. Skipping that shift keeps the freshly loaded MSB.
        if (load_q)
            tx_d = tx_val;
        else if (fall_q && bit_cnt_q != '0)
            tx_d = tx_q << 1;

        case (state_q)
            S_IDLE: begin
                if (rise_q) begin
                    rx_d      = byte_in;
                    bit_cnt_d = BC_W'(1);
                    state_d   = S_ADDR;
                end
            end
            S_ADDR, S_DATA: begin
                if (idle_q == IC_W'(IDLE_RST)) begin
                    state_d   = S_IDLE;
                    bit_cnt_d = '0;
                    rx_d      = '0;
                end else if (rise_q) begin
                    rx_d      = byte_in;
                    bit_cnt_d = bit_cnt_q + BC_W'(1);
                    if (bit_cnt_q == BC_W'(DATA_W - 1)) begin
                        bit_cnt_d = '0;
                        done_d    = 1'b1;
                        load_d    = 1'b1;
                        addr_d    = addr_nxt;
                        if (state_q == S_ADDR) begin
                            state_d = S_DATA;
                            win_d   = rc_win;
                            ch_d    = rc_ch;
                            idx_d   = rc_idx;
                        end else begin
                            for (int k = 0; k < NUM_CFG; k++) begin
                                if (addr_q == ADDR_W'(CFG_BASE + k)) cfg_d[k] = byte_in;
                            end
                            if (win_q) begin
                                if (idx_q == IDX_W'(REGS_PER_CH - 1)) begin
                                    idx_d = '0;
                                    if (ch_q == CH_W'(NUM_CH - 1)) begin
                                        win_d = 1'b0;
                                        ch_d  = '0;
                                    end else begin
                                        ch_d  = ch_q + CH_W'(1);
                                    end
                                end else begin
                                    idx_d = idx_q + IDX_W'(1);
                                end
                            end else begin
                                win_d = rc_win;
                                ch_d  = rc_ch;
                                idx_d = rc_idx;
                            end
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset takes priority over every event in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            idle_q    <= '0;
            addr_q    <= '0;
            cfg_q     <= '0;
            tx_q      <= '0;
            load_q    <= 1'b0;
            done_q    <= 1'b0;
            win_q     <= 1'b0;
            ch_q      <= '0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            idle_q    <= idle_d;
            addr_q    <= addr_d;
            cfg_q     <= cfg_d;
            tx_q      <= tx_d;
            load_q    <= load_d;
            done_q    <= done_d;
            win_q     <= win_d;
            ch_q      <= ch_d;
            idx_q     <= idx_d;
        end
    end

    assign serial_out   = tx_q[DATA_W-1];
    assign cfg_regs     = cfg_q;
    assign load_cnt_ser = win_q ? (NUM_CH'(1) << ch_q) : '0;
    assign select_reg   = win_q ? idx_q : '0;
    assign addr         = addr_q;
    assign frame_active = (state_q != S_IDLE);
    assign byte_done    = done_q;

endmodule

// File: tb/tb_spi_regfile_slave.sv
// Directed bench for spi_regfile_slave. The stimulus thread acts as the SPI
// master and pushes the expected result of each byte into a scoreboard. A
// monitor pops and checks one entry on every byte_done pulse. The external
// counter mux is modelled as rd_data = register address.
module tb_spi_regfile_slave;

    localparam int H = 5;  // sclk half period in clk cycles

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk;
    logic        serial_in;
    logic [7:0]  rd_data;
    logic        serial_out;
    logic [23:0] cfg_regs;
    logic [7:0]  load_cnt_ser;
    logic [2:0]  select_reg;
    logic [7:0]  addr;
    logic        frame_active;
    logic        byte_done;

    spi_regfile_slave dut (
        .clk          (clk),
        .rst          (rst),
        .sclk         (sclk),
        .serial_in    (serial_in),
        .rd_data      (rd_data),
        .serial_out   (serial_out),
        .cfg_regs     (cfg_regs),
        .load_cnt_ser (load_cnt_ser),
        .select_reg   (select_reg),
        .addr         (addr),
        .frame_active (frame_active),
        .byte_done    (byte_done)
    );

    always #5 clk = ~clk;

    // Counter mux model: the selected channel/reg returns its own address.
    always_comb begin
        rd_data = 8'h00;
        for (int c = 0; c < 8; c++)
            if (load_cnt_ser[c]) rd_data = 8'(4 + c * 7 + int'(select_reg));
    end

    typedef struct packed {
        logic [7:0]  addr;
        logic [7:0]  lcs;
        logic [2:0]  sel;
        logic [23:0] cfg;
        logic        chk_miso;
        logic [7:0]  miso;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         n_chk  = 0;
    int         n_fail = 0;
    int         n_done = 0;
    logic [7:0] miso_byte = 8'h00;
    logic [2:0][7:0] cfg_m = '0;
    int         cur_a = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endfunction

    function automatic logic [7:0] m_lcs(input int a);
        if (a >= 4 && a < 60) return 8'(1 << ((a - 4) / 7));
        return 8'h00;
    endfunction

    function automatic logic [2:0] m_sel(input int a);
        if (a >= 4 && a < 60) return 3'((a - 4) % 7);
        return 3'd0;
    endfunction

    function automatic logic [7:0] m_reg(input int a);
        if (a >= 1 && a <= 3) return cfg_m[a-1];
        if (a >= 4 && a < 60) return 8'(a);
        return 8'h00;
    endfunction

    // Monitor: one scoreboard entry per completed byte.
    always @(negedge clk) begin
        if (!rst && byte_done) begin
            n_done++;
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_byte_done: got addr 0x%0h, expected no byte", addr);
            end else begin
                mon_e = sb_q.pop_front();
                chk("addr", 32'(addr), 32'(mon_e.addr));
                chk("load_cnt_ser", 32'(load_cnt_ser), 32'(mon_e.lcs));
                chk("select_reg", 32'(select_reg), 32'(mon_e.sel));
                chk("cfg_regs", 32'(cfg_regs), 32'(mon_e.cfg));
                if (mon_e.chk_miso) chk("miso_byte", 32'(miso_byte), 32'(mon_e.miso));
            end
        end
    end

    // Mode-0 master: MOSI is set while sclk is low, and MISO is captured at each rise.
    task automatic spi_bits(input logic [7:0] mosi, input int nbits);
        logic [7:0] cap;
        cap = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            serial_in = mosi[7-i];
            repeat (H) @(negedge clk);
            sclk = 1'b1;
            cap  = {cap[6:0], serial_out};
            if (i == 7) miso_byte = cap;
            repeat (H) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic is_addr);
        exp_t e;
        e = '0;
        if (is_addr) begin
            cur_a      = int'(b);
            e.chk_miso = 1'b0;
        end else begin
            e.chk_miso = 1'b1;
            e.miso     = m_reg(cur_a);
            if (cur_a >= 1 && cur_a <= 3) cfg_m[cur_a-1] = b;
            cur_a = (cur_a + 1) % 256;
        end
        e.addr = 8'(cur_a);
        e.lcs  = m_lcs(cur_a);
        e.sel  = m_sel(cur_a);
        e.cfg  = cfg_m;
        sb_q.push_back(e);
        spi_bits(b, 8);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst = 1'b1; sclk = 1'b0; serial_in = 1'b0;
        repeat (3) @(negedge clk);
        // 1: reset state
        chk("rst_cfg", 32'(cfg_regs), 32'h0);
        chk("rst_miso", 32'(serial_out), 32'h0);
        chk("rst_lcs", 32'(load_cnt_ser), 32'h0);
        chk("rst_frame", 32'(frame_active), 32'h0);
        chk("rst_addr", 32'(addr), 32'h0);
        rst = 1'b0;
        idle(4);

        // 2: write the three config regs
        d0 = n_done;
        send(8'h01, 1'b1); send(8'h29, 1'b0); send(8'h06, 1'b0); send(8'h04, 1'b0);
        idle(25);
        chk("t2_cfg", 32'(cfg_regs), 32'h040629);
        chk("t2_addr", 32'(addr), 32'd4);
        chk("t2_frame_timeout", 32'(frame_active), 32'h0);
        chk("t2_byte_done_cnt", 32'(n_done - d0), 32'd4);

        // 3: sweep the whole read window and one address past it
        send(8'h04, 1'b1);
        for (int i = 0; i < 56; i++) begin
            send(8'h00, 1'b0);
            if (i == 54) begin
                chk("t3_addr59", 32'(addr), 32'd59);
                chk("t3_lcs59", 32'(load_cnt_ser), 32'h80);
                chk("t3_sel59", 32'(select_reg), 32'd6);
            end
        end
        idle(25);
        chk("t3_addr60", 32'(addr), 32'd60);
        chk("t3_lcs60", 32'(load_cnt_ser), 32'h0);
        chk("t3_sel60", 32'(select_reg), 32'h0);

        // 4: read config back; same values are written again
        send(8'h01, 1'b1); send(8'h29, 1'b0); send(8'h06, 1'b0); send(8'h04, 1'b0);
        idle(25);
        chk("t4_cfg", 32'(cfg_regs), 32'h040629);

        // 5: timeout after 5 bits of a data byte
        send(8'h01, 1'b1);
        d0 = n_done;
        spi_bits(8'hFF, 5);
        idle(25);
        chk("t5_frame", 32'(frame_active), 32'h0);
        chk("t5_addr", 32'(addr), 32'd1);
        chk("t5_cfg", 32'(cfg_regs), 32'h040629);
        chk("t5_no_done", 32'(n_done - d0), 32'd0);
        send(8'h02, 1'b1); send(8'h11, 1'b0);
        idle(25);
        chk("t5_cfg_after", 32'(cfg_regs), 32'h041129);

        // 6: address wrap, ignored writes, then reset mid-frame
        send(8'hFF, 1'b1); send(8'hAA, 1'b0); send(8'h55, 1'b0);
        chk("t6_addr_wrap", 32'(addr), 32'd1);
        chk("t6_cfg", 32'(cfg_regs), 32'h041129);
        spi_bits(8'h0F, 3);
        chk("t6_frame_mid", 32'(frame_active), 32'h1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_rst_frame", 32'(frame_active), 32'h0);
        chk("t6_rst_cfg", 32'(cfg_regs), 32'h0);
        chk("t6_rst_miso", 32'(serial_out), 32'h0);
        chk("t6_rst_addr", 32'(addr), 32'h0);
        rst = 1'b0;
        cfg_m = '0; cur_a = 0;
        idle(10);

        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
